// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache, one-word blocks.
//
// Pipeline side : dREN/dWEN/daddr/dstore in, dhit/dmemload out (zero-cycle hit).
// Memory side   : single-word ramREN/ramWEN transactions on ramaddr/ramstore,
//                 ramload returned, each transaction completes on a mem_wait=0 cycle.
// Halt          : halt with no pending request writes back every dirty frame,
//                 then flushed is held high until RST.
//
// Ports
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   dREN, dWEN         pipeline read / write request (write wins if both set)
//   daddr, dstore      byte address (bits [1:0] ignored), write data
//   halt               request flush of dirty frames
//   dhit, dmemload     request completed this cycle, read data
//   flushed            flush complete (sticky until reset)
//   ramREN, ramWEN     memory read / write request
//   ramaddr, ramstore  memory word address, write data
//   ramload, mem_wait  memory read data, memory busy
module dcache_wb #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        mem_wait
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_ALLOC,
    S_FLUSH,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [IDX-1:0]    cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [TAGW-1:0]   tag_d  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       data_d [SETS];

  logic [IDX-1:0]    idx;
  logic [TAGW-1:0]   tag;
  logic              req;
  logic              is_write;
  logic              hit;
  logic              flush_step;
  logic              unused_byte_off;

  assign idx      = daddr[IDX+1:2];
  assign tag      = daddr[31:IDX+2];
  assign req      = dREN | dWEN;
  assign is_write = dWEN;
  assign hit      = req & valid_q[idx] & (tag_q[idx] == tag);

  // Byte offset within the word plays no part in the lookup.
  assign unused_byte_off = ^daddr[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    flush_step = 1'b0;

    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      S_IDLE: begin
        // A pending request is always served before a halt is honoured.
        if (req) begin
          if (hit) begin
            dhit = 1'b1;
            if (is_write) begin
              data_d[idx]  = dstore;
              dirty_d[idx] = 1'b1;
            end else begin
              dmemload = data_q[idx];
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = S_WB;
          end else begin
            state_d = S_ALLOC;
          end
        end else if (halt) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end

      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = {tag_q[idx], idx, 2'b00};
        ramstore = data_q[idx];
        if (!mem_wait) begin
          dirty_d[idx] = 1'b0;
          state_d      = S_ALLOC;
        end
      end

      S_ALLOC: begin
        ramREN  = 1'b1;
        ramaddr = {daddr[31:2], 2'b00};
        if (!mem_wait) begin
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          tag_d[idx]   = tag;
          data_d[idx]  = ramload;
          state_d      = S_IDLE;
        end
      end

      S_FLUSH: begin
        // Clean or invalid frames take one cycle; dirty ones hold until written.
        if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
          ramWEN   = 1'b1;
          ramaddr  = {tag_q[cnt_q], cnt_q, 2'b00};
          ramstore = data_q[cnt_q];
          if (!mem_wait) begin
            dirty_d[cnt_q] = 1'b0;
            flush_step     = 1'b1;
          end
        end else begin
          flush_step = 1'b1;
        end
        if (flush_step) begin
          if (cnt_q == IDX'(SETS - 1)) begin
            state_d = S_HALTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_HALTED: begin
        flushed = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed scoreboard bench for dcache_wb (SETS=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Expected read data and expected memory transactions are
// queued before each step and popped as the DUT produces them.
module tb_dcache_wb;

  logic        CLK;
  logic        RST;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        mem_wait;

  dcache_wb #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .halt     (halt),
    .dhit     (dhit),
    .dmemload (dmemload),
    .flushed  (flushed),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .mem_wait (mem_wait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } ramx_t;

  ramx_t       ram_exp [$];
  logic [31:0] rd_exp  [$];
  logic [31:0] memm    [logic [31:0]];

  int total = 0;
  int bad   = 0;
  int cyc;
  int rcyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return memm.exists(a) ? memm[a] : (32'hBAD0_0000 ^ a);
  endfunction

  function automatic ramx_t rx(input logic wen, input logic [31:0] a, input logic [31:0] d);
    ramx_t r;
    r.wen  = wen;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  // Acts as the memory controller (mem_wait high for 'waits' cycles per
  // transaction) until dhit (or flushed when to_flush) is seen.
  task automatic run(input bit to_flush, input int waits, output int ncyc, output int nram);
    int    wcnt;
    bit    done;
    bit    active;
    ramx_t e;
    wcnt = 0;
    done = 1'b0;
    ncyc = 0;
    nram = 0;
    while (!done && ncyc < 80) begin
      ncyc++;
      active   = ramREN | ramWEN;
      mem_wait = active && (wcnt < waits);
      ramload  = active ? mem_rd(ramaddr) : '0;
      @(negedge CLK);
      if (to_flush ? flushed : dhit) begin
        done = 1'b1;
        if (!to_flush && dREN && !dWEN) begin
          if (rd_exp.size() == 0) chk("rd_sb_empty", 32'(rd_exp.size()), 32'd1);
          else                    chk("dmemload", dmemload, rd_exp.pop_front());
        end
      end else begin
        if (to_flush) chk("dhit_in_flush", 32'(dhit), 32'd0);
        if (ramREN || ramWEN) begin
          nram++;
          if (ram_exp.size() == 0) begin
            chk("ram_sb_empty", 32'(ram_exp.size()), 32'd1);
          end else begin
            e = ram_exp[0];
            chk("ramWEN", 32'(ramWEN), 32'(e.wen));
            chk("ramREN", 32'(ramREN), 32'(!e.wen));
            chk("ramaddr", ramaddr, e.addr);
            if (e.wen) chk("ramstore", ramstore, e.data);
            if (!mem_wait) begin
              if (ramWEN) memm[ramaddr] = ramstore;
              void'(ram_exp.pop_front());
              wcnt = 0;
            end else begin
              wcnt++;
            end
          end
        end
      end
      @(posedge CLK);
      #1;
    end
    chk("timeout", 32'(done), 32'd1);
    chk("ram_sb_left", 32'(ram_exp.size()), 32'd0);
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, output int ncyc, output int nram);
    dREN   = rd;
    dWEN   = wr;
    daddr  = a;
    dstore = wd;
    run(1'b0, waits, ncyc, nram);
  endtask

  initial begin
    RST      = 1'b1;
    dREN     = 1'b1;
    dWEN     = 1'b0;
    daddr    = 32'h40;
    dstore   = '0;
    halt     = 1'b0;
    ramload  = '0;
    mem_wait = 1'b0;
    memm[32'h40] = 32'hDEAD_BEEF;
    memm[32'h80] = 32'hCAFE_F00D;
    memm[32'h0C] = 32'h0000_00C0;
    memm[32'h1C] = 32'h0000_01C0;

    // Reset with a request pending: everything quiet.
    #1;
    chk("rst_dhit",     32'(dhit),    32'd0);
    chk("rst_ramREN",   32'(ramREN),  32'd0);
    chk("rst_ramWEN",   32'(ramWEN),  32'd0);
    chk("rst_flushed",  32'(flushed), 32'd0);
    chk("rst_dmemload", dmemload,     32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    dREN = 1'b0;

    // Reset asserted mid-cycle during a fill: outputs drop at once.
    dREN  = 1'b1;
    daddr = 32'h100;
    @(posedge CLK);
    #1;
    mem_wait = 1'b1;
    @(negedge CLK);
    chk("fill_ramREN", 32'(ramREN), 32'd1);
    chk("fill_ramaddr", ramaddr, 32'h100);
    RST = 1'b1;
    #1;
    chk("midrst_ramREN",   32'(ramREN),  32'd0);
    chk("midrst_ramaddr",  ramaddr,      32'd0);
    chk("midrst_dhit",     32'(dhit),    32'd0);
    chk("midrst_flushed",  32'(flushed), 32'd0);
    chk("midrst_dmemload", dmemload,     32'd0);
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    dREN     = 1'b0;
    mem_wait = 1'b0;

    // Cold read miss, two wait cycles: 3 ALLOC cycles, then a hit.
    ram_exp.push_back(rx(1'b0, 32'h40, 32'h0));
    rd_exp.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h40, 32'h0, 2, cyc, rcyc);
    chk("cold_ram_cycles", rcyc, 3);
    chk("cold_cycles", cyc, 5);

    // Repeat read: same-cycle hit, no memory traffic.
    rd_exp.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, cyc, rcyc);
    chk("rehit_cycles", cyc, 1);
    chk("rehit_ram_cycles", rcyc, 0);

    // Write hit, then conflicting read: write-back of 0x40 then fill of 0x80.
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 0, cyc, rcyc);
    chk("whit_cycles", cyc, 1);
    ram_exp.push_back(rx(1'b1, 32'h40, 32'h1234_5678));
    ram_exp.push_back(rx(1'b0, 32'h80, 32'h0));
    rd_exp.push_back(32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h80, 32'h0, 1, cyc, rcyc);
    chk("conflict_ram_cycles", rcyc, 4);
    chk("conflict_cycles", cyc, 6);
    chk("wb_mem_data", mem_rd(32'h40), 32'h1234_5678);

    // Clean victim: no write-back, reload returns the written-back word.
    ram_exp.push_back(rx(1'b0, 32'h40, 32'h0));
    rd_exp.push_back(32'h1234_5678);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, cyc, rcyc);
    chk("clean_miss_cycles", cyc, 3);

    // dREN & dWEN together on a hit behaves as a write and dirties the frame.
    access(1'b1, 1'b1, 32'h40, 32'hA1B2_C3D4, 0, cyc, rcyc);
    chk("rw_hit_cycles", cyc, 1);
    rd_exp.push_back(32'hA1B2_C3D4);
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, cyc, rcyc);
    ram_exp.push_back(rx(1'b1, 32'h40, 32'hA1B2_C3D4));
    ram_exp.push_back(rx(1'b0, 32'h80, 32'h0));
    rd_exp.push_back(32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h80, 32'h0, 0, cyc, rcyc);
    chk("rw_dirty_wb_cycles", cyc, 4);

    // Dirty sets 3 and 7 via write misses.
    ram_exp.push_back(rx(1'b0, 32'h0C, 32'h0));
    access(1'b0, 1'b1, 32'h0C, 32'h3333_0003, 0, cyc, rcyc);
    chk("wmiss3_cycles", cyc, 3);
    ram_exp.push_back(rx(1'b0, 32'h1C, 32'h0));
    access(1'b0, 1'b1, 32'h1C, 32'h7777_0007, 0, cyc, rcyc);

    // Halt raised with a miss pending: miss completes first.
    halt = 1'b1;
    ram_exp.push_back(rx(1'b0, 32'h104, 32'h0));
    rd_exp.push_back(mem_rd(32'h104));
    access(1'b1, 1'b0, 32'h104, 32'h0, 0, cyc, rcyc);
    chk("halt_miss_cycles", cyc, 3);
    chk("halt_not_flushed", 32'(flushed), 32'd0);

    // Flush: exactly sets 3 and 7 written, one write-wait cycle each.
    ram_exp.push_back(rx(1'b1, 32'h0C, 32'h3333_0003));
    ram_exp.push_back(rx(1'b1, 32'h1C, 32'h7777_0007));
    run(1'b1, 1, cyc, rcyc);
    chk("flush_cycles", cyc, 2 + 16 + 2);
    chk("flush_ram_cycles", rcyc, 4);
    chk("flush_mem3", mem_rd(32'h0C), 32'h3333_0003);
    chk("flush_mem7", mem_rd(32'h1C), 32'h7777_0007);

    // Halted: no hits even on a resident address, flushed sticky.
    halt  = 1'b0;
    dREN  = 1'b1;
    daddr = 32'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("halted_dhit",    32'(dhit),    32'd0);
      chk("halted_flushed", 32'(flushed), 32'd1);
      chk("halted_ram",     32'(ramREN | ramWEN), 32'd0);
      @(posedge CLK);
      #1;
    end
    dREN = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
Direct-mapped, write-back, write-allocate data cache with one-word blocks. It services the pipeline's memory-stage data requests (dREN/dWEN/daddr/dstore) and returns dhit/dmemload, which gate pipeline latch advance. It is the responder for those requests. On the memory side it issues single-word ramREN/ramWEN transactions to the memory controller. On halt it writes back all dirty frames and then signals flushed.

Parameters:
SETS, 16, number of frames; power of two, >=2. IDX = log2(SETS).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
dREN  in  1  pipeline data read request
dWEN  in  1  pipeline data write request
daddr  in  32  byte address; bits [1:0] ignored
dstore  in  32  write data
halt  in  1  processor halted; request flush
dhit  out  1  request completed this cycle
dmemload  out  32  read data, valid when dhit & dREN
flushed  out  1  flush complete; sticky until reset
ramREN  out  1  memory read request
ramWEN  out  1  memory write request
ramaddr  out  32  memory word address, [1:0]=00
ramstore  out  32  memory write data
ramload  in  32  memory read data, valid when ~mem_wait
mem_wait  in  1  memory busy; transaction completes on cycle mem_wait=0

Behaviour:
- Address split: tag = daddr[31:IDX+2], index = daddr[IDX+1:2].
- Frame contents: valid, dirty, tag, data[31:0].
- Reset (async, any state): all valid/dirty cleared, data/tags cleared, state=IDLE, flush counter=0. All outputs 0 immediately, including mid-transaction.
- Request: req = dREN|dWEN. If both are set, the request is a write (dWEN priority).
- hit = req & valid[index] & tag match.
- Output rules:
  - dhit is combinational and asserted only in IDLE on a hit: zero-cycle hit latency.
  - dmemload = frame data when dhit & read; otherwise 0.
  - ram* outputs are 0 except in the states listed below.
- FSM states: IDLE, WB, ALLOC, FLUSH, HALTED.
- IDLE:
  - Read hit: dhit=1, no state change.
  - Write hit: dhit=1; at the clock edge data<=dstore, dirty<=1.
  - Miss with victim valid & dirty -> WB. Miss otherwise -> ALLOC.
  - No req & halt -> FLUSH with counter=0. A pending req takes priority over halt.
- WB:
  - ramWEN=1, ramaddr={victim tag, index, 2'b00}, ramstore=victim data.
  - On ~mem_wait: dirty<=0, -> ALLOC.
- ALLOC:
  - ramREN=1, ramaddr={daddr[31:2],2'b00}.
  - On ~mem_wait: valid<=1, tag<=tag, data<=ramload, dirty<=0, -> IDLE.
  - The request then hits on the next cycle: a clean miss costs (ALLOC cycles + 1); a dirty miss adds the WB cycles.
- Miss handling relies on the pipeline holding dREN/dWEN/daddr/dstore stable while dhit=0. Behaviour under changing inputs mid-miss is undefined.
- FLUSH, per set counter c:
  - If valid & dirty: ramWEN=1, ramaddr={tag[c], c, 2'b00}, ramstore=data[c]. On ~mem_wait: dirty<=0, c++.
  - If clean: c++ with no memory access, one cycle.
  - When c=SETS-1 completes -> HALTED.
  - dhit=0 throughout; req ignored.
- HALTED: flushed=1, all other outputs 0. Held until RST; halt and req are ignored.
- Counter wraps only via reset; there is no re-entry to FLUSH.

Test Plan:
1. Reset: assert RST mid-cycle with dREN=1 -> dhit, ramREN, ramWEN, flushed and dmemload are 0 immediately. After release, state is IDLE and every access misses.
2. Cold read miss: dREN, daddr=0x40, mem_wait high for 2 cycles, ramload=0xDEADBEEF. Required response:
   - ramREN=1, ramaddr=0x40 for 3 cycles.
   - Next cycle dhit=1, dmemload=0xDEADBEEF.
   - Repeat read -> dhit same cycle with no ram traffic.
3. Write-hit then conflict (SETS=16): write 0x40 <- 0x12345678 (hit after fill), then dREN 0x80. Required response:
   - ramWEN, ramaddr=0x40, ramstore=0x12345678 until ~mem_wait.
   - Then ramREN, ramaddr=0x80.
   - Then dhit.
4. Flush: sets 3 and 7 dirty, others clean or invalid; halt=1 with no request. Required response:
   - Exactly two ramWEN transactions, at set 3 then set 7 addresses, with stored data.
   - Total cycles = 16 + write-wait cycles.
   - flushed=1 thereafter; later dREN gets no dhit.
5. Simultaneous dREN&dWEN on a hit -> treated as a write: frame updated to dstore, dirty set.
6. Halt with a pending miss -> the miss completes (dhit asserted) before FLUSH starts.
